// File: rtl/keypad_matrix_scan.sv
// Matrix keypad scanner: one-hot row drive, whole-frame debounce, debounced key bitmap,
// and a small press/release event FIFO with a valid/ready head.
module keypad_matrix_scan #(
  parameter int ROWS     = 4,
  parameter int COLS     = 3,
  parameter int DEBOUNCE = 20,
  parameter int EV_DEPTH = 4,
  localparam int N  = ROWS * COLS,
  localparam int KW = (N > 1) ? $clog2(N) : 1,
  localparam int LW = $clog2(EV_DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [COLS-1:0] keypadc,
  output logic [ROWS-1:0] keypadr,
  output logic [N-1:0]    pressed,
  output logic            event_valid,
  input  logic            event_ready,
  output logic [KW-1:0]   event_key,
  output logic            event_press,
  output logic [LW-1:0]   ev_level
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int PW = (EV_DEPTH > 1) ? $clog2(EV_DEPTH) : 1;

  logic [RW-1:0]   row_reg;
  logic [ROWS-1:0] drive_reg;
  logic [COLS-1:0] frame_cur_reg [ROWS];
  logic [N-1:0]    frame_prev_reg;
  logic [N-1:0]    pressed_reg;
  logic [N-1:0]    pending_reg;
  logic [N-1:0]    pending_next;
  logic [N-1:0]    frame_full;
  logic [7:0]      cnt_reg;

  logic last_row;
  logic frame_same;
  logic commit;

  // The completed frame takes its top row straight from the live column sense.
  genvar gi;
  generate
    for (gi = 0; gi < ROWS - 1; gi++) begin : g_frame
      assign frame_full[gi*COLS +: COLS] = frame_cur_reg[gi];
    end
  endgenerate
  assign frame_full[(ROWS-1)*COLS +: COLS] = keypadc;

  assign last_row   = (row_reg == RW'(ROWS - 1));
  assign frame_same = (frame_full == frame_prev_reg);
  assign commit     = en && last_row && frame_same && (cnt_reg == 8'(DEBOUNCE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_reg        <= '0;
      drive_reg      <= ROWS'(1);
      frame_prev_reg <= '0;
      pressed_reg    <= '0;
      cnt_reg        <= '0;
      for (int i = 0; i < ROWS; i++) frame_cur_reg[i] <= '0;
    end else if (en) begin
      frame_cur_reg[row_reg] <= keypadc;
      if (last_row) begin
        row_reg        <= '0;
        drive_reg      <= ROWS'(1);
        frame_prev_reg <= frame_full;
        if (!frame_same || cnt_reg == 8'(DEBOUNCE - 1)) cnt_reg <= '0;
        else cnt_reg <= cnt_reg + 8'd1;
        if (commit) pressed_reg <= frame_full;
      end else begin
        row_reg   <= row_reg + RW'(1);
        drive_reg <= drive_reg << 1;
      end
    end
  end

  // Event side: lowest pending key wins, one push per cycle, independent of en.
  logic [KW:0]   mem [EV_DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [LW-1:0] level_reg;
  logic [LW-1:0] level_next;
  logic [KW-1:0] sel_k;
  logic          sel_found;
  logic          fifo_full;
  logic          push;
  logic          pop;
  logic [N-1:0]  clear_mask;
  logic [KW:0]   head;

  always_comb begin
    sel_found = 1'b0;
    sel_k     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pending_reg[i]) begin
        sel_found = 1'b1;
        sel_k     = KW'(i);
      end
    end
  end

  assign fifo_full  = (level_reg == LW'(EV_DEPTH));
  assign pop        = (level_reg != '0) && event_ready;
  assign push       = sel_found && (!fifo_full || pop);
  assign clear_mask = push ? (N'(1) << sel_k) : '0;

  always_comb begin
    pending_next = pending_reg & ~clear_mask;
    if (commit) pending_next = pending_next ^ (frame_full ^ pressed_reg);
  end

  always_comb begin
    level_next = level_reg;
    case ({push, pop})
      2'b10:   level_next = level_reg + LW'(1);
      2'b01:   level_next = level_reg - LW'(1);
      default: level_next = level_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg <= '0;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      level_reg   <= '0;
    end else begin
      pending_reg <= pending_next;
      level_reg   <= level_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= {sel_k, pressed_reg[sel_k]};
  end

  assign head        = mem[rd_ptr_reg];
  assign keypadr     = drive_reg;
  assign pressed     = pressed_reg;
  assign event_valid = (level_reg != '0);
  assign event_key   = event_valid ? head[KW:1] : '0;
  assign event_press = event_valid ? head[0] : 1'b0;
  assign ev_level    = level_reg;

endmodule

// File: tb/tb_keypad_matrix_scan.sv
// Bench for keypad_matrix_scan: directed scenarios plus random key/enable/ready traffic,
// checked each clock against a frame-level reference model with an event queue.
module tb_keypad_matrix_scan;
  localparam int ROWS = 4;
  localparam int COLS = 3;
  localparam int DEB  = 2;
  localparam int DEPTH = 2;
  localparam int N  = ROWS * COLS;
  localparam int KW = 4;
  localparam int LW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic event_ready = 1'b0;
  logic [COLS-1:0] keypadc;
  logic [ROWS-1:0] keypadr;
  logic [N-1:0] pressed;
  logic event_valid;
  logic [KW-1:0] event_key;
  logic event_press;
  logic [LW-1:0] ev_level;
  logic [N-1:0] key_down = '0;

  int checks = 0;
  int failures = 0;
  int edge_n = 0;

  keypad_matrix_scan #(.ROWS(ROWS), .COLS(COLS), .DEBOUNCE(DEB), .EV_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .keypadc(keypadc), .keypadr(keypadr),
    .pressed(pressed), .event_valid(event_valid), .event_ready(event_ready),
    .event_key(event_key), .event_press(event_press), .ev_level(ev_level)
  );

  always #5 clk = ~clk;

  // Physical switch matrix: a closed key connects its row drive to its column.
  always_comb begin
    keypadc = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (keypadr[r] && key_down[r*COLS+c]) keypadc[c] = 1'b1;
  end

  // Reference model state: events are encoded key*2+press in a queue.
  int m_row, m_cnt;
  logic [N-1:0] m_cur, m_prev, m_pressed, m_pending;
  int m_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_row = 0; m_cnt = 0;
    m_cur = '0; m_prev = '0; m_pressed = '0; m_pending = '0;
    m_q.delete();
  endtask

  task automatic model_step(input logic e, input logic rdy, input logic [N-1:0] kd);
    logic [N-1:0] f;
    logic [N-1:0] diff;
    bit pop;
    int k;
    int ev;
    pop = (m_q.size() > 0) && rdy;
    k = -1;
    ev = 0;
    if (m_pending != '0 && (m_q.size() < DEPTH || pop)) begin
      for (int i = 0; i < N; i++)
        if (m_pending[i] && k < 0) k = i;
      ev = k * 2 + int'(m_pressed[k]);
    end
    if (pop) void'(m_q.pop_front());
    if (k >= 0) begin
      m_q.push_back(ev);
      m_pending[k] = 1'b0;
    end
    if (e) begin
      f = m_cur;
      f[m_row*COLS +: COLS] = kd[m_row*COLS +: COLS];
      if (m_row == ROWS - 1) begin
        if (f == m_prev) begin
          if (m_cnt == DEB - 1) begin
            diff = f ^ m_pressed;
            m_pending = m_pending ^ diff;
            m_pressed = f;
            m_cnt = 0;
          end else m_cnt++;
        end else m_cnt = 0;
        m_prev = f;
      end
      m_cur = f;
      m_row = (m_row + 1) % ROWS;
    end
  endtask

  task automatic compare_all();
    check("keypadr", keypadr, 32'(1) << m_row);
    check("pressed", pressed, m_pressed);
    check("ev_level", ev_level, m_q.size());
    check("event_valid", event_valid, m_q.size() != 0);
    check("event_key", event_key, (m_q.size() != 0) ? (m_q[0] >> 1) : 0);
    check("event_press", event_press, (m_q.size() != 0) ? (m_q[0] & 1) : 0);
  endtask

  task automatic tick();
    logic e, r;
    logic [N-1:0] kd;
    e = en; r = event_ready; kd = key_down;
    @(posedge clk);
    model_step(e, r, kd);
    edge_n++;
    #1;
    compare_all();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_keypadr"}, keypadr, 1);
    check({tag, "_pressed"}, pressed, 0);
    check({tag, "_valid"}, event_valid, 0);
    check({tag, "_level"}, ev_level, 0);
    check({tag, "_key"}, event_key, 0);
    check({tag, "_press"}, event_press, 0);
  endtask

  // Asynchronous reset pulse; released on a falling edge so edge 1 samples row 0.
  task automatic do_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs(tag);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    edge_n = 0;
  endtask

  task automatic wait_row(input logic [ROWS-1:0] target);
    int n;
    n = 0;
    while (keypadr !== target && n < 20) begin tick(); n++; end
    check("wait_row_timeout", keypadr, target);
  endtask

  initial begin
    int n, cnt7, other_ev;
    int seq[$];

    model_reset();
    #7 check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;

    // Idle scan, no keys: rotation and silence are covered by the model.
    repeat (12) tick();

    // Key 5 held from reset, commit on edge 12, event on the following edge.
    key_down = 12'h020;
    event_ready = 1'b1;
    do_reset("rst_b");
    repeat (11) tick();
    check("pre_commit_pressed", pressed, 0);
    tick();
    check("commit12_pressed", pressed, 12'h020);
    tick();
    check("ev5_valid", event_valid, 1);
    check("ev5_key", event_key, 5);
    check("ev5_press", event_press, 1);
    tick();
    check("ev5_gone", event_valid, 0);
    key_down = '0;
    n = 0;
    while (!(event_valid === 1'b1) && n < 40) begin tick(); n++; end
    check("rel5_seen", event_valid, 1);
    check("rel5_key", event_key, 5);
    check("rel5_press", event_press, 0);
    repeat (6) tick();

    // Key 7 bounces frame by frame, then settles: exactly one press event.
    wait_row(4'b0001);
    cnt7 = 0; other_ev = 0;
    for (int f = 0; f < 18; f++) begin
      key_down = (f >= 10 || (f % 2) == 0) ? 12'h080 : 12'h000;
      for (int j = 0; j < ROWS; j++) begin
        tick();
        if (event_valid === 1'b1 && event_ready) begin
          if (event_key === 4'd7 && event_press === 1'b1) cnt7++;
          else other_ev++;
        end
      end
    end
    check("bounce_press_count", cnt7, 1);
    check("bounce_other_events", other_ev, 0);
    key_down = '0;
    repeat (20) tick();

    // Three simultaneous presses into a two-deep FIFO with the consumer stalled.
    event_ready = 1'b0;
    wait_row(4'b0001);
    key_down = 12'hA04;
    n = 0;
    while (ev_level !== 2'd2 && n < 60) begin tick(); n++; end
    repeat (3) tick();
    check("fifo_full_level", ev_level, 2);
    check("fifo_head_key", event_key, 2);
    event_ready = 1'b1;
    n = 0;
    while (seq.size() < 3 && n < 20) begin
      if (event_valid === 1'b1) seq.push_back(int'(event_key));
      tick(); n++;
    end
    check("drain_count", seq.size(), 3);
    if (seq.size() == 3) begin
      check("drain_0", seq[0], 2);
      check("drain_1", seq[1], 9);
      check("drain_2", seq[2], 11);
    end
    key_down = '0;
    repeat (30) tick();

    // Enable dropped with row 2 driven for 50 cycles, key 4 mid-debounce.
    wait_row(4'b0001);
    key_down = 12'h010;
    repeat (6) tick();
    check("pre_freeze_row", keypadr, 4'b0100);
    en = 1'b0;
    repeat (50) tick();
    check("frozen_row", keypadr, 4'b0100);
    check("frozen_pressed", pressed, 0);
    en = 1'b1;
    repeat (20) tick();
    check("resume_pressed", pressed, 12'h010);
    key_down = '0;
    repeat (20) tick();

    // Reset while key 0 is committed and its event is queued.
    event_ready = 1'b0;
    key_down = 12'h001;
    n = 0;
    while (ev_level !== 2'd1 && n < 40) begin tick(); n++; end
    check("key0_queued", ev_level, 1);
    do_reset("rst_mid");
    event_ready = 1'b1;
    n = 0;
    while (event_valid !== 1'b1 && n < 40) begin tick(); n++; end
    check("rearm_latency", edge_n, (DEB + 1) * ROWS + 1);
    check("rearm_key", event_key, 0);
    check("rearm_press", event_press, 1);
    key_down = '0;
    repeat (20) tick();

    // Random traffic: sparse key changes, occasional enable drops, bursty ready.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 15) == 0) key_down = N'($urandom) & N'($urandom);
      en = ($urandom_range(0, 9) != 0);
      event_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 700) == 0) do_reset("rst_rand");
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
